fp8_div_seq: RTL and testbench
==============================

# fp8_div_seq

Sequential FP8 divider: the inverse operation of the team's combinational FP8 multiplier, using the same 1-4-3 encoding (bias 7, every encoding treated as normal with hidden 1, no zero/Inf/NaN handling). It accepts one dividend/divisor pair over a valid/ready handshake and computes the mantissa quotient with a bit-serial restoring divider, one bit per cycle. It then returns the result over a second valid/ready handshake. It sits beside the multiplier in the FP8 datapath and lets the tile perform a/b without a combinational divider array.

## Interface
- EXP_BITS, 4, exponent width
- MANTISSA_BITS, 3, stored mantissa width
- BIAS, (1<<(EXP_BITS-1))-1 = 7, exponent bias
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  8  dividend {sign, exp[3:0], man[2:0]}
- b  in  8  divisor, same format
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  8  quotient {sign, exp, man}
- exc  out  1  exponent out of range 0..15 (result exponent wrapped)

## Operation
- States: IDLE, CALC, DONE. The state register resets to IDLE.
- in_ready = (state==IDLE) && !rst. Combinational.
- out_valid = (state==DONE). Registered, not combinational.
- IDLE: on in_valid && in_ready, latch the following and go to CALC:
  - sign = a[7]^b[7]
  - Ea, Eb
  - dividend Da = {1,a[2:0]}, divisor Db = {1,b[2:0]}
  - iteration counter = 0
  - a/b changes after the accept edge have no effect.
- CALC: restoring division producing N = MANTISSA_BITS+2 = 5 quotient bits, MSB first, one bit per cycle. The result is qm = floor(Da*16/Db), in range 8..30.
  - Each iteration: shift the partial remainder left by 1, bringing in the next dividend bit (zeros after Da is exhausted). If remainder ≥ Db, subtract and set the quotient bit to 1.
  - The remainder register needs 5 bits.
- Normalisation, applied on the last iteration:
  - If qm[4]=1: man = qm[3:1], adj = 0.
  - Else: man = qm[2:0], adj = 1.
  - Rounding is truncation (toward zero).
- Exponent: e = Ea − Eb + BIAS − adj, computed in signed EXP_BITS+2 bits.
  - exc = (e<0) || (e>15).
  - Result exponent = e[3:0], i.e. wrap-around, matching the multiplier.
- The last CALC iteration registers q = {sign, e[3:0], man} and exc, then moves to DONE.
- DONE: q, exc and out_valid hold stable until out_valid && out_ready, then the block returns to IDLE.
- q and exc keep their last value in IDLE and CALC. Only out_valid qualifies them.
- Reset, at any state including mid-CALC or DONE:
  - Next edge: state=IDLE, out_valid=0, q=0x00, exc=0, counter=0, remainder=0.
  - In-flight operations are discarded with no output.
  - in_ready is 0 while rst is high.

## Timing
- Accept at edge T. Iterations occur at edges T+1..T+5. DONE is entered at edge T+5, so out_valid is high in the cycle after edge T+5 (latency 5).
- With out_ready held high: transfer at edge T+6, IDLE after edge T+6, next accept earliest at edge T+7. Maximum throughput is 1 result per 7 cycles.
- No overlap: in_ready=0 during CALC and DONE, and in_valid is ignored there.
- out_ready during IDLE/CALC is ignored.

## Test plan
- 1.0/1.0: a=0x38, b=0x38, accept at edge T → out_valid rises after edge T+5, q=0x38, exc=0.
- Quotient ≥1 with truncation, sign: a=0x3C (1.5), b=0x3A (1.25) → q=0x39 (qm=19), exc=0. Repeat with a=0xBC → q=0xB9.
- Quotient <1 normalisation: a=0x38, b=0x3C → qm=10, q=0x32 (0.625), exc=0.
- Exponent range:
  - Overflow: a=0x78, b=0x08 → e=21, q=0x28, exc=1.
  - Underflow: a=0x08, b=0x78 → e=−7, q=0x48, exc=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → q/exc/out_valid stable, in_ready=0, toggling in_valid/a/b ignored. Raise out_ready → transfer at that edge, in_ready=1 next cycle, new operands then accepted.
- Reset mid-CALC: assert rst for one cycle at the 3rd iteration → out_valid=0 and q=0x00 after that edge, no result is ever emitted for the aborted operands. A fresh accept afterwards produces a correct result with latency 5.

Source files
------------

// File: rtl/fp8_div_seq.sv
// Sequential FP8 (1-4-3, bias 7) divider: handshake in, bit-serial restoring
// mantissa division (one quotient bit per cycle), handshake out.
module fp8_div_seq #(
  parameter int EXP_BITS      = 4,
  parameter int MANTISSA_BITS = 3,
  parameter int BIAS          = (1 << (EXP_BITS - 1)) - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_BITS+MANTISSA_BITS:0]   a,
  input  logic [EXP_BITS+MANTISSA_BITS:0]   b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_BITS+MANTISSA_BITS:0]   q,
  output logic                              exc
);

  localparam int N     = MANTISSA_BITS + 2;
  localparam int CNT_W = $clog2(N);
  localparam int E_W   = EXP_BITS + 2;
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(N - 1);
  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EMAX   = E_W'((1 << EXP_BITS) - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                     state, state_nxt;
  logic                       sign;
  logic [EXP_BITS-1:0]        ea, eb;
  logic [MANTISSA_BITS:0]     db;
  logic                       da_lsb;
  logic [CNT_W-1:0]           cnt;
  logic [N-1:0]               rem;
  logic [N-2:0]               qm;

  logic                       bit_in;
  logic [N-1:0]               rem_sh;
  logic                       ge;
  logic [N-1:0]               rem_nxt;
  logic [N-1:0]               qm_nxt;
  logic                       adj;
  logic [MANTISSA_BITS-1:0]   man;
  logic signed [E_W-1:0]      e;
  logic                       e_exc;

  // Returns {adj, man}: truncating normalisation of the 5-bit quotient.
  function automatic logic [MANTISSA_BITS:0] normalize(input logic [N-1:0] qv);
    if (qv[N-1]) return {1'b0, qv[MANTISSA_BITS:1]};
    else         return {1'b1, qv[MANTISSA_BITS-1:0]};
  endfunction

  function automatic logic exp_out_of_range(input logic signed [E_W-1:0] ev);
    return ev[E_W-1] || (ev > EMAX);
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Remainder is preloaded with Da[3:1]; Da[0] then zeros are shifted in.
  always_comb begin
    bit_in  = (cnt == '0) ? da_lsb : 1'b0;
    rem_sh  = {rem[N-2:0], bit_in};
    ge      = ({rem[N-1], rem_sh} >= {2'b00, db});
    rem_nxt = ge ? (rem_sh - {1'b0, db}) : rem_sh;
    qm_nxt  = {qm, ge};
    {adj, man} = normalize(qm_nxt);
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S
        - $signed({{(E_W-1){1'b0}}, adj});
    e_exc = exp_out_of_range(e);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = CALC;
      CALC:    if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      qm  <= '0;
      q   <= '0;
      exc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign   <= a[EXP_BITS+MANTISSA_BITS] ^ b[EXP_BITS+MANTISSA_BITS];
          ea     <= a[MANTISSA_BITS +: EXP_BITS];
          eb     <= b[MANTISSA_BITS +: EXP_BITS];
          db     <= {1'b1, b[MANTISSA_BITS-1:0]};
          da_lsb <= a[0];
          rem    <= {2'b00, 1'b1, a[MANTISSA_BITS-1:1]};
          qm     <= '0;
          cnt    <= '0;
        end
        CALC: begin
          rem <= rem_nxt;
          qm  <= qm_nxt[N-2:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            q   <= {sign, e[EXP_BITS-1:0], man};
            exc <= e_exc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_div_seq.sv
// Randomized and directed bench for fp8_div_seq against an arithmetic reference model.
module tb_fp8_div_seq;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] a, b, q;
  logic       in_ready, out_valid, exc;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  fp8_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .exc(exc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {exc, q} computed from real-valued mantissa quotient rules.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
    int da, db, qm, adj, man, e, ex, ey;
    logic [7:0] r;
    da = 8 + int'(x[2:0]);
    db = 8 + int'(y[2:0]);
    ex = int'(x[6:3]);
    ey = int'(y[6:3]);
    qm = (da * 16) / db;
    if (qm >= 16) begin man = (qm / 2) % 8; adj = 0; end
    else          begin man = qm % 8;       adj = 1; end
    e = ex - ey + 7 - adj;
    r = {x[7] ^ y[7], e[3:0], man[2:0]};
    return {(e < 0) || (e > 15), r};
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int hold);
    int lat;
    logic [8:0] ex;
    ex = model(x, y);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", lat, 5);
    check("q", q, {24'd0, ex[7:0]});
    check("exc", exc, {31'd0, ex[8]});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_q", q, {24'd0, ex[7:0]});
      check("hold_exc", exc, {31'd0, ex[8]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("xfer_valid_low", out_valid, 0);
    check("xfer_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_exc", exc, 0);
    check("rst_in_ready", in_ready, 1);

    do_op(8'h38, 8'h38, 0);
    check("dir_1_0", q, 8'h38);
    do_op(8'h3C, 8'h3A, 0);
    check("dir_trunc", q, 8'h39);
    do_op(8'hBC, 8'h3A, 0);
    check("dir_sign", q, 8'hB9);
    do_op(8'h38, 8'h3C, 10);
    check("dir_norm", q, 8'h32);
    do_op(8'h78, 8'h08, 0);
    check("dir_ovf_q", q, 8'h28);
    check("dir_ovf_exc", exc, 1);
    do_op(8'h08, 8'h78, 2);
    check("dir_unf_q", q, 8'h48);
    check("dir_unf_exc", exc, 1);

    // Abort an operation with reset on its 3rd iteration edge.
    in_valid = 1'b1; a = 8'h3C; b = 8'h3A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("in_ready_rst_high", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_q", q, 0);
    check("abort_exc", exc, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(8'h38, 8'h3C, 0);

    for (int i = 0; i < 40; i++)
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
